apb_slave_regbank: RTL and testbench

// APB completer at the far end of the bridge's APB master port: decodes one Pselx bit and serves

---
 rtl/apb_slave_regbank_if.sv | 16 +
 rtl/apb_slave_regbank.sv | 80 ++++++++
 tb/tb_apb_slave_regbank.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regbank_if.sv
// apb_slave_regbank_if: APB completer-side bus bundle with bridge (master) and peripheral (slave) views
interface apb_slave_regbank_if #(
    parameter int WIDTH  = 32,
    parameter int SLAVES = 2
);
    logic [SLAVES-1:0] Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [WIDTH-1:0]  Paddr;
    logic [WIDTH-1:0]  Pwdata;
    logic [WIDTH-1:0]  Prdata;
    logic              Pready;
    logic              Pslverr;
    modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata, input Prdata, Pready, Pslverr);
    modport slave (input Pselx, Penable, Pwrite, Paddr, Pwdata, output Prdata, Pready, Pslverr);
endinterface

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB completer serving a DEPTH-word register bank with wait states and error response
module apb_slave_regbank #(
    parameter int                 WIDTH       = 32,
    parameter int                 SEL_IDX     = 0,
    parameter logic [WIDTH-1:0]   BASE_ADDR   = 32'h8000_0000,
    parameter int                 DEPTH       = 16,
    parameter int                 WAIT_STATES = 0
) (
    input logic                Hclk,
    input logic                Hreset,
    apb_slave_regbank_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
    state_t           state;
    logic [WIDTH-1:0] bank [DEPTH];
    logic [WIDTH-1:0] prdata, wdata, off, rd_n;
    logic             pready, pslverr, wr, err, sel, setup, err_n, commit;
    logic [AW-1:0]    idx, idx_n;
    logic [3:0]       cnt;
    assign sel    = bus.Pselx[SEL_IDX];
    assign setup  = sel && !bus.Penable;
    assign off    = bus.Paddr - BASE_ADDR;
    assign idx_n  = off[2 +: AW];
    assign err_n  = (off >= WIDTH'(DEPTH * 4)) || (bus.Paddr[1:0] != 2'b00);
    assign commit = (state == ACCESS) && wr && !err;
    assign rd_n   = (commit && idx == idx_n) ? wdata : bank[idx_n];
    assign bus.Prdata  = prdata;
    assign bus.Pready  = pready;
    assign bus.Pslverr = pslverr;
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state   <= IDLE;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            wr      <= 1'b0;
            wdata   <= '0;
            err     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            if (commit) bank[idx] <= wdata;
            case (state)
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (!sel) state <= IDLE;
                    else if (cnt == 4'd1) begin
                        state   <= ACCESS;
                        pready  <= 1'b1;
                        pslverr <= err;
                        prdata  <= (!wr && !err) ? bank[idx] : '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    if (setup) begin
                        idx   <= idx_n;
                        wr    <= bus.Pwrite;
                        wdata <= bus.Pwdata;
                        err   <= err_n;
                        if (WAIT_STATES == 0) begin
                            state   <= ACCESS;
                            pready  <= 1'b1;
                            pslverr <= err_n;
                            prdata  <= (!bus.Pwrite && !err_n) ? rd_n : '0;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_STATES);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank: directed and random APB transfers against three bank instances and an array model
module tb_apb_slave_regbank;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int TMO = 30;
    logic        Hclk = 1'b0;
    logic        Hreset;
    logic [1:0]  psel [3];
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] rdv [3];
    logic        rdy [3];
    logic        sev [3];
    logic [31:0] model [3][16];
    int          ws [3] = '{0, 3, 4};
    int          total = 0;
    int          passed = 0;
    always #5 Hclk = ~Hclk;
    apb_slave_regbank_if #(.WIDTH(32), .SLAVES(2)) if0 ();
    apb_slave_regbank_if #(.WIDTH(32), .SLAVES(2)) if1 ();
    apb_slave_regbank_if #(.WIDTH(32), .SLAVES(2)) if2 ();
    assign if0.Pselx = psel[0];
    assign if1.Pselx = psel[1];
    assign if2.Pselx = psel[2];
    assign {if0.Penable, if1.Penable, if2.Penable} = {3{penable}};
    assign {if0.Pwrite, if1.Pwrite, if2.Pwrite}    = {3{pwrite}};
    assign {if0.Paddr, if1.Paddr, if2.Paddr}       = {3{paddr}};
    assign {if0.Pwdata, if1.Pwdata, if2.Pwdata}    = {3{pwdata}};
    assign rdv = '{if0.Prdata, if1.Prdata, if2.Prdata};
    assign rdy = '{if0.Pready, if1.Pready, if2.Pready};
    assign sev = '{if0.Pslverr, if1.Pslverr, if2.Pslverr};
    apb_slave_regbank #(.WAIT_STATES(0)) d0 (.Hclk(Hclk), .Hreset(Hreset), .bus(if0));
    apb_slave_regbank #(.WAIT_STATES(3)) d1 (.Hclk(Hclk), .Hreset(Hreset), .bus(if1));
    apb_slave_regbank #(.WAIT_STATES(4)) d2 (.Hclk(Hclk), .Hreset(Hreset), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) model[k][i] = '0;
    endtask

    task automatic chk_quiet(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_pready"}, 32'(rdy[k]), 0);
            chk({tag, "_pslverr"}, 32'(sev[k]), 0);
            chk({tag, "_prdata"}, rdv[k], 0);
        end
    endtask

    task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [31:0] d, input bit sel_ok);
        logic [31:0] off, erd, rd;
        bit          e, se, bad;
        int          i, lat;
        off = a - BASE;
        e   = (off >= 64) || (a % 4 != 0);
        i   = int'((off / 4) % 16);
        erd = (sel_ok && !w && !e) ? model[k][i] : 32'h0;
        bad = 1'b0;
        lat = 0;
        @(negedge Hclk);
        chk("pre_pready", 32'(rdy[k]), 0);
        psel[k] = sel_ok ? 2'b01 : 2'b10;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
        @(posedge Hclk) #1 penable = 1'b1;
        @(negedge Hclk);
        while (!rdy[k] && lat < TMO) begin
            if (rdv[k] !== 0 || sev[k] !== 1'b0) bad = 1'b1;
            paddr  = $urandom;
            pwdata = $urandom;
            pwrite = 1'($urandom);
            @(negedge Hclk);
            lat++;
        end
        rd = rdv[k];
        se = sev[k];
        @(posedge Hclk) #1;
        psel[k] = 2'b00;
        penable = 1'b0;
        chk("latency", lat, sel_ok ? ws[k] : TMO);
        chk("wait_quiet", 32'(bad), 0);
        chk("prdata", rd, erd);
        chk("pslverr", 32'(se), 32'(sel_ok && e));
        if (sel_ok && w && !e) model[k][i] = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int r;
        psel = '{2'b00, 2'b00, 2'b00};
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = '0;
        pwdata = '0;
        Hreset = 1'b1;
        clear_model();
        repeat (2) @(posedge Hclk);
        #1 Hreset = 1'b0;
        @(negedge Hclk);
        chk_quiet("reset");
        xfer(0, 1'b1, BASE + 32'h4, $urandom | 32'h1, 1'b1);
        for (int n = 0; n < 5; n++) xfer(0, 1'b1, BASE + 4 * $urandom_range(0, 15), $urandom, 1'b1);
        xfer(0, 1'b0, BASE + 32'h4, 0, 1'b1);
        @(posedge Hclk) #1 Hreset = 1'b1;
        repeat (2) @(posedge Hclk);
        #1 Hreset = 1'b0;
        clear_model();
        @(negedge Hclk);
        chk_quiet("rst2");
        xfer(0, 1'b0, BASE + 32'h4, 0, 1'b1);
        xfer(0, 1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 1'b1);
        xfer(0, 1'b0, BASE + 32'h8, 0, 1'b1);
        chk("deadbeef", model[0][2], 32'hDEAD_BEEF);
        xfer(1, 1'b1, BASE, 32'h0BAD_F00D, 1'b1);
        xfer(1, 1'b0, BASE, 0, 1'b1);
        xfer(1, 1'b1, BASE + 32'hC, $urandom, 1'b1);
        xfer(1, 1'b0, BASE + 32'hC, 0, 1'b1);
        xfer(0, 1'b1, BASE, 32'h1111_2222, 1'b1);
        xfer(0, 1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 1'b1);
        xfer(0, 1'b1, BASE + 32'h2, 32'hFFFF_FFFF, 1'b1);
        xfer(0, 1'b0, BASE + 32'h40, 0, 1'b1);
        xfer(0, 1'b0, BASE, 0, 1'b1);
        xfer(0, 1'b1, BASE + 32'h8, 32'h1234_5678, 1'b0);
        xfer(0, 1'b0, BASE + 32'h8, 0, 1'b1);
        xfer(2, 1'b1, BASE + 32'h10, 32'hA5A5_A5A5, 1'b1);
        @(negedge Hclk);
        psel[2] = 2'b01;
        pwrite = 1'b1;
        paddr = BASE + 32'h10;
        pwdata = 32'h5A5A_5A5A;
        @(posedge Hclk) #1 penable = 1'b1;
        repeat (2) @(posedge Hclk);
        #1 psel[2] = 2'b00;
        penable = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge Hclk);
            chk("abort_pready", 32'(rdy[2]), 0);
        end
        xfer(2, 1'b0, BASE + 32'h10, 0, 1'b1);
        @(negedge Hclk);
        psel[2] = 2'b01;
        pwrite = 1'b1;
        paddr = BASE + 32'h14;
        pwdata = 32'h7777_7777;
        @(posedge Hclk) #1 penable = 1'b1;
        @(posedge Hclk) #1 Hreset = 1'b1;
        @(posedge Hclk) #1 Hreset = 1'b0;
        clear_model();
        for (int n = 0; n < 6; n++) begin
            @(negedge Hclk);
            chk("rstmid_pready", 32'(rdy[2]), 0);
        end
        psel[2] = 2'b00;
        penable = 1'b0;
        xfer(2, 1'b0, BASE + 32'h14, 0, 1'b1);
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            a = r < 7 ? BASE + 4 * $urandom_range(0, 15) :
                r == 7 ? BASE + 64 + 4 * $urandom_range(0, 100) :
                r == 8 ? BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3) :
                BASE - 4 * $urandom_range(1, 8);
            xfer($urandom_range(0, 2), 1'($urandom), a, $urandom, 1'b1);
        end
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) xfer(k, 1'b0, BASE + 4 * i, 0, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
